// File: rtl/mem_pkg.sv
// Shared parameter defaults and FSM state encoding for the memory responder.
package mem_pkg;

   localparam int CPU_ADDR_BITS_DEF = 26;
   localparam int TAG_BITS_DEF      = 5;
   localparam int DATA_BITS_DEF     = 128;
   localparam int BEATS_DEF         = 4;
   localparam int LINE_BITS_DEF     = 8;
   localparam int READ_LATENCY_DEF  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      RWAIT = 2'd2,
      RRESP = 2'd3
   } state_t;

endpackage

// File: rtl/mem_resp_array.sv
// Line storage: simple dual-port RAM, one write and one registered read port.
// A write and a read to the same address in one cycle returns the old word.
module mem_resp_array #(
   parameter int ADDR_BITS = 10,
   parameter int DEPTH     = 1024,
   parameter int DATA_BITS = 128
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [DATA_BITS-1:0] rd_data
);

   logic [DATA_BITS-1:0] mem [DEPTH];

   // Write port: contents are never cleared, so they survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port: the word addressed this cycle appears on rd_data next cycle.
   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Cache-line memory responder: accepts one command at a time, absorbs the
// write beats of a line or streams the beats of a line back after a fixed
// read latency.
module mem_responder
   import mem_pkg::*;
#(
   parameter int CPU_ADDR_BITS = CPU_ADDR_BITS_DEF,
   parameter int TAG_BITS      = TAG_BITS_DEF,
   parameter int DATA_BITS     = DATA_BITS_DEF,
   parameter int BEATS         = BEATS_DEF,
   parameter int LINE_BITS     = LINE_BITS_DEF,
   parameter int READ_LATENCY  = READ_LATENCY_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     io_mem_req_cmd_ready,
   input  logic                     io_mem_req_cmd_valid,
   input  logic [CPU_ADDR_BITS-1:0] io_mem_req_cmd_bits_addr,
   input  logic [TAG_BITS-1:0]      io_mem_req_cmd_bits_tag,
   input  logic                     io_mem_req_cmd_bits_rw,
   output logic                     io_mem_req_data_ready,
   input  logic                     io_mem_req_data_valid,
   input  logic [DATA_BITS-1:0]     io_mem_req_data_bits_data,
   input  logic                     io_mem_resp_ready,
   output logic                     io_mem_resp_valid,
   output logic [DATA_BITS-1:0]     io_mem_resp_bits_data,
   output logic [TAG_BITS-1:0]      io_mem_resp_bits_tag
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DEPTH  = (2 ** LINE_BITS) * BEATS;
   localparam int RAM_AW = $clog2(DEPTH);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [3:0]        LAT_LAST  = 4'(READ_LATENCY - 1);

   state_t                 state_reg, state_next;
   logic [BEAT_W-1:0]      beat_cnt_reg, beat_cnt_next;
   logic [3:0]             lat_cnt_reg, lat_cnt_next;
   logic [TAG_BITS-1:0]    tag_reg, tag_next;
   logic [LINE_BITS-1:0]   line_reg, line_next;

   logic [LINE_BITS-1:0]   cmd_line;
   logic [LINE_BITS-1:0]   rd_line;
   logic [BEAT_W-1:0]      rd_beat;
   logic [RAM_AW-1:0]      ram_rd_addr;
   logic [RAM_AW-1:0]      ram_wr_addr;
   logic [DATA_BITS-1:0]   ram_rd_data;
   logic                   ram_wr_en;

   // Upper address bits only alias lines together; they carry no storage.
   assign cmd_line = io_mem_req_cmd_bits_addr[LINE_BITS-1:0];

   generate
      if (CPU_ADDR_BITS > LINE_BITS) begin : g_alias
         logic unused_addr_bits;
         assign unused_addr_bits = ^io_mem_req_cmd_bits_addr[CPU_ADDR_BITS-1:LINE_BITS];
      end
   endgenerate

   assign ram_wr_en   = io_mem_req_data_valid & io_mem_req_data_ready;
   assign ram_wr_addr = RAM_AW'(line_reg) * RAM_AW'(BEATS) + RAM_AW'(beat_cnt_reg);
   assign ram_rd_addr = RAM_AW'(rd_line) * RAM_AW'(BEATS) + RAM_AW'(rd_beat);

   mem_resp_array #(
      .ADDR_BITS (RAM_AW),
      .DEPTH     (DEPTH),
      .DATA_BITS (DATA_BITS)
   ) u_array (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (io_mem_req_data_bits_data),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data)
   );

   // State and transaction context registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         beat_cnt_reg <= '0;
         lat_cnt_reg  <= '0;
         tag_reg      <= '0;
         line_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         beat_cnt_reg <= beat_cnt_next;
         lat_cnt_reg  <= lat_cnt_next;
         tag_reg      <= tag_next;
         line_reg     <= line_next;
      end
   end

   // Next state, handshakes, and the RAM read address one beat ahead of the
   // response so a beat can be delivered every cycle.
   always_comb begin
      state_next            = state_reg;
      beat_cnt_next         = beat_cnt_reg;
      lat_cnt_next          = lat_cnt_reg;
      tag_next              = tag_reg;
      line_next             = line_reg;
      rd_line               = line_reg;
      rd_beat               = beat_cnt_reg;
      io_mem_req_cmd_ready  = 1'b0;
      io_mem_req_data_ready = 1'b0;
      io_mem_resp_valid     = 1'b0;
      io_mem_resp_bits_data = '0;
      io_mem_resp_bits_tag  = '0;

      case (state_reg)
         IDLE: begin
            io_mem_req_cmd_ready = rst_n;
            // Prefetch beat 0 of the incoming line for the zero-latency case.
            rd_line = cmd_line;
            rd_beat = '0;
            if (io_mem_req_cmd_valid && io_mem_req_cmd_ready) begin
               tag_next      = io_mem_req_cmd_bits_tag;
               line_next     = cmd_line;
               beat_cnt_next = '0;
               lat_cnt_next  = '0;
               if (io_mem_req_cmd_bits_rw) begin
                  state_next = WDATA;
               end else if (READ_LATENCY == 0) begin
                  state_next = RRESP;
               end else begin
                  state_next = RWAIT;
               end
            end
         end
         WDATA: begin
            io_mem_req_data_ready = rst_n;
            if (io_mem_req_data_valid && io_mem_req_data_ready) begin
               if (beat_cnt_reg == LAST_BEAT) begin
                  beat_cnt_next = '0;
                  state_next    = IDLE;
               end else begin
                  beat_cnt_next = beat_cnt_reg + 1'b1;
               end
            end
         end
         RWAIT: begin
            rd_beat = '0;
            if (lat_cnt_reg == LAT_LAST) begin
               lat_cnt_next = '0;
               state_next   = RRESP;
            end else begin
               lat_cnt_next = lat_cnt_reg + 1'b1;
            end
         end
         RRESP: begin
            io_mem_resp_valid     = rst_n;
            io_mem_resp_bits_data = rst_n ? ram_rd_data : '0;
            io_mem_resp_bits_tag  = rst_n ? tag_reg : '0;
            if (io_mem_resp_valid && io_mem_resp_ready) begin
               rd_beat = beat_cnt_reg + 1'b1;
               if (beat_cnt_reg == LAST_BEAT) begin
                  beat_cnt_next = '0;
                  state_next    = IDLE;
               end else begin
                  beat_cnt_next = beat_cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a transaction table plus hand-written
// sequences for backpressure, gating, reset mid-write and zero latency.
module tb_mem_responder;

   localparam int AW = 26;
   localparam int TW = 5;
   localparam int DW = 128;

   typedef logic [3:0][DW-1:0] line_t;

   typedef struct {
      logic          rw;
      logic [AW-1:0] addr;
      logic [TW-1:0] tag;
      logic [DW-1:0] base;
      int            stall_beat;
      int            stall_n;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic [AW-1:0] cmd_addr;
   logic [TW-1:0] cmd_tag;
   logic          cmd_rw;
   logic          data_valid;
   logic [DW-1:0] wdata;
   logic          resp_ready;

   logic          d2_cmd_ready, d2_data_ready, d2_resp_valid;
   logic [DW-1:0] d2_resp_data;
   logic [TW-1:0] d2_resp_tag;
   logic          d0_cmd_ready, d0_data_ready, d0_resp_valid;
   logic [DW-1:0] d0_resp_data;
   logic [TW-1:0] d0_resp_tag;

   logic          sel = 1'b0;
   logic          obs_cmd_ready, obs_data_ready, obs_resp_valid;
   logic [DW-1:0] obs_resp_data;
   logic [TW-1:0] obs_resp_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign obs_cmd_ready  = sel ? d0_cmd_ready  : d2_cmd_ready;
   assign obs_data_ready = sel ? d0_data_ready : d2_data_ready;
   assign obs_resp_valid = sel ? d0_resp_valid : d2_resp_valid;
   assign obs_resp_data  = sel ? d0_resp_data  : d2_resp_data;
   assign obs_resp_tag   = sel ? d0_resp_tag   : d2_resp_tag;

   mem_responder dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .io_mem_req_cmd_ready      (d2_cmd_ready),
      .io_mem_req_cmd_valid      (cmd_valid),
      .io_mem_req_cmd_bits_addr  (cmd_addr),
      .io_mem_req_cmd_bits_tag   (cmd_tag),
      .io_mem_req_cmd_bits_rw    (cmd_rw),
      .io_mem_req_data_ready     (d2_data_ready),
      .io_mem_req_data_valid     (data_valid),
      .io_mem_req_data_bits_data (wdata),
      .io_mem_resp_ready         (resp_ready),
      .io_mem_resp_valid         (d2_resp_valid),
      .io_mem_resp_bits_data     (d2_resp_data),
      .io_mem_resp_bits_tag      (d2_resp_tag)
   );

   mem_responder #(.READ_LATENCY(0)) dut0 (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .io_mem_req_cmd_ready      (d0_cmd_ready),
      .io_mem_req_cmd_valid      (cmd_valid),
      .io_mem_req_cmd_bits_addr  (cmd_addr),
      .io_mem_req_cmd_bits_tag   (cmd_tag),
      .io_mem_req_cmd_bits_rw    (cmd_rw),
      .io_mem_req_data_ready     (d0_data_ready),
      .io_mem_req_data_valid     (data_valid),
      .io_mem_req_data_bits_data (wdata),
      .io_mem_resp_ready         (resp_ready),
      .io_mem_resp_valid         (d0_resp_valid),
      .io_mem_resp_bits_data     (d0_resp_data),
      .io_mem_resp_bits_tag      (d0_resp_tag)
   );

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic line_t mk(input logic [DW-1:0] base);
      line_t r;
      for (int i = 0; i < 4; i++) r[i] = base + DW'(i);
      return r;
   endfunction

   // Present a command at the next falling edge and hold it until cmd_ready.
   task automatic issue_cmd(input logic [AW-1:0] a, input logic [TW-1:0] tg, input logic rw);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_tag   = tg;
      cmd_rw    = rw;
      n = 0;
      while (!obs_cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_bit("cmd_ready", obs_cmd_ready, 1'b1);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [TW-1:0] tg, input line_t d,
                           input logic hold_cmd);
      int n;
      issue_cmd(a, tg, 1'b1);
      @(negedge clk);
      if (!hold_cmd) cmd_valid = 1'b0;
      else cmd_rw = 1'b0;
      data_valid = 1'b1;
      wdata      = d[0];
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!obs_data_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         check_bit("data_ready", obs_data_ready, 1'b1);
         if (hold_cmd) check_bit("cmd_ready_in_wdata", obs_cmd_ready, 1'b0);
         @(negedge clk);
         if (i < 3) wdata = d[i + 1];
         else data_valid = 1'b0;
      end
      check_bit("cmd_ready_after_write", obs_cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      $display("write addr=%0h tag=%0d beat0=%0h", a, tg, d[0]);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [TW-1:0] tg, input line_t exp,
                          input int stall_beat, input int stall_n, input int exp_lat);
      int n;
      issue_cmd(a, tg, 1'b0);
      @(negedge clk);
      cmd_valid  = 1'b0;
      resp_ready = 1'b1;
      n = 1;
      while (!obs_resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("read_latency", DW'(n), DW'(exp_lat));
      for (int i = 0; i < 4; i++) begin
         check_bit("resp_valid", obs_resp_valid, 1'b1);
         check_val("resp_data", obs_resp_data, exp[i]);
         check_val("resp_tag", DW'(obs_resp_tag), DW'(tg));
         if (i == stall_beat) begin
            resp_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               @(negedge clk);
               check_bit("stall_valid", obs_resp_valid, 1'b1);
               check_val("stall_data", obs_resp_data, exp[i]);
               check_val("stall_tag", DW'(obs_resp_tag), DW'(tg));
            end
            resp_ready = 1'b1;
         end
         @(negedge clk);
      end
      check_bit("resp_valid_after_read", obs_resp_valid, 1'b0);
      check_bit("cmd_ready_after_read", obs_cmd_ready, 1'b1);
      $display("read  addr=%0h tag=%0d beat0=%0h latency=%0d", a, tg, exp[0], n);
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{1'b1, 26'h005,  5'd3,  128'hA0, -1, 0};
      vecs[1] = '{1'b0, 26'h005,  5'd7,  128'hA0, -1, 0};
      vecs[2] = '{1'b0, 26'h005,  5'd9,  128'hA0,  1, 5};
      vecs[3] = '{1'b1, 26'h105,  5'd1,  128'hB0, -1, 0};
      vecs[4] = '{1'b0, 26'h005,  5'd2,  128'hB0, -1, 0};
      vecs[5] = '{1'b1, 26'h0FF,  5'd31, 128'hC0, -1, 0};
      vecs[6] = '{1'b0, 26'h3FF,  5'd12, 128'hC0,  0, 2};
      vecs[7] = '{1'b1, 26'h010,  5'd4,  128'hD0, -1, 0};
      vecs[8] = '{1'b0, 26'h010,  5'd5,  128'hD0,  3, 1};

      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_addr   = '0;
      cmd_tag    = '0;
      cmd_rw     = 1'b0;
      data_valid = 1'b0;
      wdata      = '0;
      resp_ready = 1'b0;

      // Outputs held low during reset, cmd_ready up right after release.
      repeat (3) @(negedge clk);
      check_bit("rst_cmd_ready", obs_cmd_ready, 1'b0);
      check_bit("rst_data_ready", obs_data_ready, 1'b0);
      check_bit("rst_resp_valid", obs_resp_valid, 1'b0);
      check_val("rst_resp_data", obs_resp_data, '0);
      check_val("rst_resp_tag", DW'(obs_resp_tag), '0);
      rst_n = 1'b1;
      @(negedge clk);
      check_bit("post_rst_cmd_ready", obs_cmd_ready, 1'b1);

      for (int v = 0; v < 9; v++) begin
         if (vecs[v].rw) do_write(vecs[v].addr, vecs[v].tag, mk(vecs[v].base), 1'b0);
         else do_read(vecs[v].addr, vecs[v].tag, mk(vecs[v].base),
                      vecs[v].stall_beat, vecs[v].stall_n, 3);
      end

      // Write beats offered while idle are neither accepted nor stored.
      @(negedge clk);
      data_valid = 1'b1;
      wdata      = 128'hEE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_bit("idle_data_ready", obs_data_ready, 1'b0);
      end
      data_valid = 1'b0;
      do_read(26'h010, 5'd6, mk(128'hD0), -1, 0, 3);

      // A command held valid during the write phase is not accepted early.
      do_write(26'h020, 5'd8, mk(128'h60), 1'b1);
      do_read(26'h020, 5'd8, mk(128'h60), -1, 0, 3);

      // Reset after two beats: those beats land, the rest stay old.
      issue_cmd(26'h010, 5'd10, 1'b1);
      @(negedge clk);
      cmd_valid  = 1'b0;
      data_valid = 1'b1;
      wdata      = 128'hF0;
      check_bit("mid_data_ready0", obs_data_ready, 1'b1);
      @(negedge clk);
      wdata = 128'hF1;
      check_bit("mid_data_ready1", obs_data_ready, 1'b1);
      @(negedge clk);
      rst_n      = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      check_bit("mid_rst_cmd_ready", obs_cmd_ready, 1'b0);
      check_bit("mid_rst_data_ready", obs_data_ready, 1'b0);
      check_bit("mid_rst_resp_valid", obs_resp_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_bit("mid_post_rst_cmd_ready", obs_cmd_ready, 1'b1);
      $display("reset mid-write addr=10 after 2 beats");
      do_read(26'h010, 5'd13, {128'hD3, 128'hD2, 128'hF1, 128'hF0}, -1, 0, 3);

      // Zero-latency instance: first beat the cycle after acceptance.
      sel = 1'b1;
      do_write(26'h033, 5'd2, mk(128'h50), 1'b0);
      do_read(26'h033, 5'd11, mk(128'h50), 2, 2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter CPU_ADDR_BITS, default 26, meaning the width of the line address on the command channel.
REQ-002 SHALL have parameter TAG_BITS, default 5, meaning the width of the transaction tag.
REQ-003 SHALL have parameter DATA_BITS, default 128, meaning the width of one data beat.
REQ-004 SHALL have parameter BEATS, default 4, meaning the number of data beats per cache line.
REQ-005 SHALL have parameter LINE_BITS, default 8, meaning log2 of the number of stored lines.
REQ-006 SHALL have parameter READ_LATENCY, default 2, range 0..15, meaning the wait cycles between read command acceptance and the first response beat.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port io_mem_req_cmd_ready, output, 1 bit: command accept.
REQ-010 SHALL have port io_mem_req_cmd_valid, input, 1 bit: command present.
REQ-011 SHALL have port io_mem_req_cmd_bits_addr, input, CPU_ADDR_BITS wide: line address.
REQ-012 SHALL have port io_mem_req_cmd_bits_tag, input, TAG_BITS wide: transaction tag.
REQ-013 SHALL have port io_mem_req_cmd_bits_rw, input, 1 bit: 1 = write, 0 = read.
REQ-014 SHALL have port io_mem_req_data_ready, output, 1 bit: write-beat accept.
REQ-015 SHALL have port io_mem_req_data_valid, input, 1 bit: write beat present.
REQ-016 SHALL have port io_mem_req_data_bits_data, input, DATA_BITS wide: write beat.
REQ-017 SHALL have port io_mem_resp_ready, input, 1 bit: requester accepts a response beat.
REQ-018 SHALL have port io_mem_resp_valid, output, 1 bit: response beat present.
REQ-019 SHALL have port io_mem_resp_bits_data, output, DATA_BITS wide: read beat.
REQ-020 SHALL have port io_mem_resp_bits_tag, output, TAG_BITS wide: tag of the read command.

Function
REQ-021 SHALL implement a four-state FSM: IDLE, WDATA, RWAIT and RRESP.
REQ-022 SHALL drive io_mem_req_cmd_ready=1 only in IDLE.
REQ-023 SHALL treat a command as accepted on any cycle where cmd_valid and cmd_ready are both 1, capturing addr, tag and rw in that cycle.
REQ-024 SHALL form the line index from addr[LINE_BITS-1:0]; upper address bits SHALL be ignored, so addresses alias modulo 2^LINE_BITS.
REQ-025 SHALL go from IDLE to WDATA on an accepted write, and to RWAIT on an accepted read (or directly to RRESP when READ_LATENCY=0).
REQ-026 SHALL drive io_mem_req_data_ready=1 only in WDATA; data_valid in any other state SHALL be ignored and not consumed.
REQ-027 SHALL, in WDATA, store each accepted beat at (line, beat_cnt) and increment beat_cnt, starting from 0.
REQ-028 SHALL return from WDATA to IDLE in the cycle after beat BEATS-1 is accepted.
REQ-029 SHALL, in RWAIT, count READ_LATENCY cycles and then enter RRESP, so that resp_valid first rises at cycle t+1+READ_LATENCY, where t is the cycle of read command acceptance.
REQ-030 SHALL, in RRESP, present beats 0..BEATS-1 of the line in order, with resp_bits_tag equal to the captured tag.
REQ-031 SHALL hold resp_valid, resp data and resp tag stable while resp_valid=1 and resp_ready=0.
REQ-032 SHALL advance one beat per cycle in which resp_valid and resp_ready are both 1; back-to-back beats SHALL be possible at full rate.
REQ-033 SHALL return from RRESP to IDLE in the cycle after the last beat handshakes.
REQ-034 SHALL never accept a new command until the previous transaction completes, so a read issued after a write to the same line returns the written data.
REQ-035 SHALL count beats in a counter of width clog2(BEATS) and wrap it to 0 at the end of each transaction.
REQ-036 SHALL return the stored contents for a read of a never-written line; those contents are undefined in simulation (X).

Reset
REQ-037 SHALL, on rst_n=0 at a clock edge, enter IDLE and clear beat_cnt, the latency counter, the captured tag and the captured line.
REQ-038 SHALL, while rst_n=0, drive cmd_ready=0, data_ready=0, resp_valid=0, resp data=0 and resp tag=0.
REQ-039 SHALL, on reset mid-transaction, abandon the transaction; beats already written SHALL remain in the array, and storage SHALL NOT be cleared.
REQ-040 SHALL drive cmd_ready=1 in the first cycle after rst_n returns to 1.

Structure
REQ-041 SHALL place the parameter defaults and the FSM state enum in shared package mem_pkg.
REQ-042 SHALL implement storage in sub-module mem_resp_array: a 1R1W synchronous RAM of depth 2^LINE_BITS*BEATS and width DATA_BITS, with registered read and a write port that does not bypass to the read port.
REQ-043 SHALL issue the RAM read one cycle ahead of each response beat, so that the response handshake stays full-rate.

Verification
REQ-044 SHALL verify write then read: write line 0x05, tag 3, beats 0xA0..0xA3; read 0x05, tag 7 -> four resp beats 0xA0..0xA3, all with tag 7, first resp_valid at cycle t+3.
REQ-045 SHALL verify backpressure: hold resp_ready=0 for 5 cycles during beat 1 -> beat 1 data and tag stay stable, no beat is skipped or repeated.
REQ-046 SHALL verify aliasing: write addr 0x105 with 0xB0..0xB3, then read addr 0x005 -> 0xB0..0xB3.
REQ-047 SHALL verify protocol gating: assert data_valid in IDLE -> data_ready stays 0 and no write occurs; assert cmd_valid during WDATA -> cmd_ready stays 0 until beat 3 is accepted.
REQ-048 SHALL verify reset mid-write: reset after beat 1 -> IDLE, cmd_ready=1 one cycle after release; read of that line returns the new beats 0 and 1 and the old beats 2 and 3.
REQ-049 SHALL verify zero latency: with READ_LATENCY=0, a read accepted at cycle t -> resp_valid=1 at cycle t+1.
